// File: rtl/traffic_light_sequencer.sv
// Round-robin multi-direction traffic light sequencer with its own
// countdown master timer, skip masking and emergency all-red override.
module traffic_light_sequencer #(
  parameter int NUM_DIR      = 4,
  parameter int DIR_W        = 2,
  parameter int TIMER_W      = 7,
  parameter int GREEN_TIME   = 105,
  parameter int YELLOW_TIME  = 15,
  parameter int ALL_RED_TIME = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               tick,
  input  logic [NUM_DIR-1:0] dir_mask,
  input  logic               emerg,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [DIR_W-1:0]   active_dir,
  output logic [TIMER_W-1:0] master_timer,
  output logic               phase_done
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    CLEAR,
    EMERG
  } state_t;

  localparam logic [TIMER_W-1:0] RELOAD =
    TIMER_W'(GREEN_TIME + YELLOW_TIME);
  localparam logic [TIMER_W-1:0] CLR_T =
    TIMER_W'(ALL_RED_TIME);
  localparam logic [TIMER_W-1:0] YEL_T =
    TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] ONE =
    TIMER_W'(1);

  state_t               state;
  state_t               state_n;
  logic [DIR_W-1:0]     dir_n;
  logic [TIMER_W-1:0]   timer_n;
  logic                 done_n;

  // First masked-in direction at (from + off), searching upward with wrap.
  function automatic logic [DIR_W-1:0] pick(
    input logic [NUM_DIR-1:0] m,
    input logic [DIR_W-1:0]   from,
    input int                 off
  );
    logic [DIR_W-1:0] r;
    logic [DIR_W-1:0] cand;
    logic             hit;
    r   = from;
    hit = 1'b0;
    for (int i = 0; i < NUM_DIR; i++) begin
      cand = DIR_W'((int'(from) + off + i) % NUM_DIR);
      if (!hit && m[cand]) begin
        r   = cand;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      active_dir   <= '0;
      master_timer <= '0;
      phase_done   <= 1'b0;
    end else begin
      state        <= state_n;
      active_dir   <= dir_n;
      master_timer <= timer_n;
      phase_done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = active_dir;
    timer_n = master_timer;
    done_n  = 1'b0;
    if (emerg) begin
      state_n = EMERG;
      timer_n = '0;
    end else if (!enable) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|dir_mask) begin
            state_n = SERVE;
            dir_n   = pick(dir_mask, active_dir, 0);
            timer_n = RELOAD;
          end
        end
        SERVE: begin
          if (tick) begin
            if (master_timer <= ONE) begin
              state_n = CLEAR;
              timer_n = CLR_T;
            end else begin
              timer_n = master_timer - ONE;
            end
          end
        end
        CLEAR: begin
          if (tick) begin
            if (master_timer <= ONE) begin
              done_n = 1'b1;
              if (|dir_mask) begin
                state_n = SERVE;
                dir_n   = pick(dir_mask, active_dir, 1);
                timer_n = RELOAD;
              end else begin
                state_n = IDLE;
                timer_n = '0;
              end
            end else begin
              timer_n = master_timer - ONE;
            end
          end
        end
        EMERG: begin
          // Released with enable high: clear the junction before moving on.
          state_n = CLEAR;
          timer_n = CLR_T;
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    if (state == SERVE) begin
      if (master_timer > YEL_T) begin
        green[active_dir] = 1'b1;
      end else begin
        yellow[active_dir] = 1'b1;
      end
    end
    red = ~(green | yellow);
  end

endmodule
